impl_chk_sched: RTL

Scheduler for a bank of N_CH single-cycle implication checkers (antecedent `a` implies consequent `b` one cycle later) with per-channel disable selection and a shared, round-robin-arbitrated failure report port. It evaluates every channel in parallel. It resolves each channel's effective disable condition, which is either the block-wide default or a per-channel explicit override. It then serializes failures to a downstream logger over a valid/ready handshake. It sits beside the datapath under check as a synthesizable monitor.

---
 rtl/impl_chk_sched.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/impl_chk_sched.sv
// impl_chk_sched: a bank of N_CH single-cycle implication checkers.
// Each checker tests that antecedent a in one cycle implies consequent b in the next.
// A disable term can abort an attempt.
// Failures are serialised to a logger through one round-robin arbitrated valid/ready port.
// Optional feature: define IMPL_CHK_DEFAULT_DIS_EN to add the dis_default input.
// When it is undefined, channels with dis_sel=0 have no disable.
module impl_chk_sched #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 16,
    localparam int CH_W = $clog2(N_CH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_CH-1:0]  ch_en,
    input  logic [N_CH-1:0]  a,
    input  logic [N_CH-1:0]  b,
`ifdef IMPL_CHK_DEFAULT_DIS_EN
    input  logic             dis_default,
`endif
    input  logic [N_CH-1:0]  dis_sel,
    input  logic [N_CH-1:0]  dis_ovr,
    output logic             rpt_valid,
    input  logic             rpt_ready,
    output logic [CH_W-1:0]  rpt_ch,
    output logic [CNT_W-1:0] rpt_stamp,
    output logic [CNT_W-1:0] fail_cnt,
    output logic             rpt_ovf,
    output logic             busy
);

    localparam int PC_W = $clog2(N_CH + 1);

    // Number of channels failing in one cycle
    function automatic logic [PC_W-1:0] popcount(input logic [N_CH-1:0] v);
        logic [PC_W-1:0] n;
        n = '0;
        for (int i = 0; i < N_CH; i++) begin
            n = n + PC_W'(v[i]);
        end
        return n;
    endfunction

    // Failure counter add that sticks at all-ones instead of wrapping
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] base,
                                                 input logic [PC_W-1:0]  inc);
        logic [CNT_W:0] sum;
        sum = {1'b0, base} + (CNT_W+1)'(inc);
        return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    endfunction

    logic [N_CH-1:0]  def_dis;
    logic [N_CH-1:0]  eff_dis;
    logic [N_CH-1:0]  pend;
    logic [N_CH-1:0]  fail;
    logic [N_CH-1:0]  fail_pend;
    logic [N_CH-1:0]  clr;
    logic [N_CH-1:0]  fp_nxt;
    logic [N_CH-1:0]  ovf_hit;
    logic [N_CH-1:0]  stamp_we;
    logic [CNT_W-1:0] stamp [N_CH];
    logic [CNT_W-1:0] cyc;
    logic [CH_W-1:0]  rr_ptr;
    logic [CH_W-1:0]  rr_nxt;
    logic [CH_W-1:0]  win_idx;
    logic             win_found;
    logic             load;

`ifdef IMPL_CHK_DEFAULT_DIS_EN
    assign def_dis = {N_CH{dis_default}};
`else
    assign def_dis = '0;
`endif

    // Resolve each channel's disable and classify the pending checks
    always_comb begin
        eff_dis = (dis_sel & dis_ovr) | (~dis_sel & def_dis);
        fail    = pend & ~eff_dis & ~b;
    end

    // Round-robin search over latched failures, starting at rr_ptr
    always_comb begin : arb
        int j;
        j         = 0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < N_CH; k++) begin
            j = int'(rr_ptr) + k;
            if (j >= N_CH) j = j - N_CH;
            if (!win_found && fail_pend[j]) begin
                win_found = 1'b1;
                win_idx   = CH_W'(j);
            end
        end
        rr_nxt = (win_idx == CH_W'(N_CH - 1)) ? '0 : win_idx + CH_W'(1);
    end

    // Update the fail_pend slots; a new failure overrides the clear of a slot being loaded
    always_comb begin
        load = ~rpt_valid | rpt_ready;
        for (int i = 0; i < N_CH; i++) begin
            clr[i] = load & win_found & (win_idx == CH_W'(i));
        end
        fp_nxt   = (fail_pend & ~clr) | fail;
        ovf_hit  = fail & fail_pend & ~clr;
        stamp_we = fail & ~(fail_pend & ~clr);
    end

    assign busy = (|pend) | (|fail_pend) | rpt_valid;

    // Per-channel attempt/failure state, cycle stamp and the failure statistics
    always_ff @(posedge clk) begin
        if (rst) begin
            pend      <= '0;
            fail_pend <= '0;
            cyc       <= '0;
            fail_cnt  <= '0;
            rpt_ovf   <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                stamp[i] <= '0;
            end
        end else begin
            pend      <= ch_en & a & ~eff_dis;
            fail_pend <= fp_nxt;
            cyc       <= cyc + CNT_W'(1);
            fail_cnt  <= sat_add(fail_cnt, popcount(fail));
            if (|ovf_hit) rpt_ovf <= 1'b1;
            for (int i = 0; i < N_CH; i++) begin
                if (stamp_we[i]) stamp[i] <= cyc;
            end
        end
    end

    // Report register: reload whenever empty or being accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            rpt_valid <= 1'b0;
            rpt_ch    <= '0;
            rpt_stamp <= '0;
            rr_ptr    <= '0;
        end else if (load) begin
            rpt_valid <= win_found;
            if (win_found) begin
                rpt_ch    <= win_idx;
                rpt_stamp <= stamp[win_idx];
                rr_ptr    <= rr_nxt;
            end
        end
    end

endmodule
